// File: rtl/fir_pkg.sv
// Shared definitions for the serial-MAC FIR filter: FSM encoding, width helper and
// the round/shift/saturate function applied to the accumulator on output.
package fir_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Accumulators up to 62 bits are handled; round half up, then clamp to out_w bits.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int unsigned        shift,
                                                   input int unsigned        out_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = acc;
    if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
    v  = v >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_serial_mac_coef_bank.sv
// Coefficient register file: one write port gated by an enable, one indexed read port.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = 13,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned AW     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            addr_i,
  input  logic signed [COEF_W-1:0] wdata_i,
  input  logic [AW-1:0]            idx_i,
  output logic signed [COEF_W-1:0] coef_o
);

  logic signed [COEF_W-1:0] coef_q [TAPS];

  // Address decode over existing entries only, so out-of-range writes fall through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (en_i && we_i) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (addr_i == AW'(i)) coef_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    coef_o = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (idx_i == AW'(i)) coef_o = coef_q[i];
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// N-tap signed FIR with one shared multiply-accumulate stepped over the taps,
// valid/ready on both sides and a rounded, shifted, saturated result.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 13,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SHIFT  = 0,
  localparam int unsigned AW    = clog2(TAPS),
  localparam int unsigned ACC_W = DATA_W + COEF_W + clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [OUT_W-1:0]  out_data_o,
  input  logic                     coef_we_i,
  input  logic [AW-1:0]            coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_wdata_i,
  output logic                     busy_o
);

  logic [1:0]               state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum, prod;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] x_sel;
  logic signed [COEF_W-1:0] c_sel;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     accept, last;

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign accept      = in_valid_i && in_ready_o;
  assign last        = (idx_q == AW'(TAPS - 1));

  fir_coef_bank #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .AW     (AW)
  ) u_coef_bank (
    .clk     (clk),
    .rst     (rst),
    .en_i    (in_ready_o),
    .we_i    (coef_we_i),
    .addr_i  (coef_addr_i),
    .wdata_i (coef_wdata_i),
    .idx_i   (idx_q),
    .coef_o  (c_sel)
  );

  always_comb begin
    x_sel = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (idx_q == AW'(i)) x_sel = x_q[i];
    end
  end

  // Operands are sign-extended to ACC_W first so the product is full-width and signed.
  assign prod    = ACC_W'(x_sel) * ACC_W'(c_sel);
  assign acc_sum = acc_q + prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
      x_q[0] <= in_data_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + AW'(1);
        if (last) begin
          out_data_d  = OUT_W'(sat_round(64'(acc_sum), SHIFT, OUT_W));
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: three instances (default, 16-bit output, SHIFT=4) share the
// stimulus and are compared with an arithmetic reference of the filter.
module tb_fir_serial_mac;

  localparam int TAPS = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               out_ready = 1'b1;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [15:0] coef_wdata = '0;

  logic rdy_def, rdy_sat, rdy_rnd, vld_def, vld_sat, vld_rnd, busy_def, busy_sat, busy_rnd;
  logic signed [31:0] out_def;
  logic signed [15:0] out_sat;
  logic signed [31:0] out_rnd;

  fir_serial_mac u_def (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_def), .in_data_i(in_data),
    .out_valid_o(vld_def), .out_ready_i(out_ready), .out_data_o(out_def),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata), .busy_o(busy_def)
  );

  fir_serial_mac #(.OUT_W(16)) u_sat (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_sat), .in_data_i(in_data),
    .out_valid_o(vld_sat), .out_ready_i(out_ready), .out_data_o(out_sat),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata), .busy_o(busy_sat)
  );

  fir_serial_mac #(.SHIFT(4)) u_rnd (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy_rnd), .in_data_i(in_data),
    .out_valid_o(vld_rnd), .out_ready_i(out_ready), .out_data_o(out_rnd),
    .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata), .busy_o(busy_rnd)
  );

  int n_checks = 0;
  int n_errors = 0;
  longint c_m [TAPS];
  longint x_m [TAPS];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_acc();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += x_m[k] * c_m[k];
    return s;
  endfunction

  // Round half up then divide by 2^s (floor), clamp to a w-bit signed range.
  function automatic longint ref_out(input longint acc, input int s, input int w);
    longint v, hi, lo, d;
    v = acc;
    d = longint'(1) << s;
    if (s > 0) v = v + d / 2;
    if (v >= 0) v = v / d;
    else v = -((-v + d - 1) / d);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < TAPS; k++) begin
      c_m[k] = 0;
      x_m[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic write_coef(input int addr, input longint v, input bit idle);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 4'(addr);
    coef_wdata = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
    if (idle && addr < TAPS) c_m[addr] = v;
  endtask

  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic accept(input longint d);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(d);
    guard = 0;
    while (!rdy_def && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("accept_timeout", 0, 1);
    @(posedge clk);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int lat);
    longint acc;
    lat = 1;
    while (!vld_def && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    acc = model_acc();
    check({tag, "/vld_sat"}, 64'(vld_sat), 1);
    check({tag, "/vld_rnd"}, 64'(vld_rnd), 1);
    check({tag, "/def"}, out_def, ref_out(acc, 0, 32));
    check({tag, "/sat"}, out_sat, ref_out(acc, 0, 16));
    check({tag, "/rnd"}, out_rnd, ref_out(acc, 4, 32));
  endtask

  task automatic run_sample(input string tag, input longint d);
    int lat;
    accept(d);
    check({tag, "/busy"}, 64'(busy_def), 1);
    wait_out(tag, lat);
    check({tag, "/lat"}, lat, TAPS + 1);
  endtask

  initial begin
    int lat;
    int seen;
    longint held;
    logic signed [15:0] r;

    clear_model();
    repeat (2) @(negedge clk);
    check("rst_vld", 64'(vld_def), 0);
    check("rst_out", out_def, 0);
    check("rst_busy", 64'(busy_def), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", 64'(rdy_def), 1);

    // Impulse response through c[k] = k+1.
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1, 1'b1);
    for (int n = 0; n <= TAPS; n++) begin
      run_sample($sformatf("imp%0d", n), (n == 0) ? 100 : 0);
      check($sformatf("imp_const%0d", n), out_def, (n < TAPS) ? 100 * (n + 1) : 0);
    end

    // Saturation at both rails.
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767, 1'b1);
    for (int n = 0; n < TAPS; n++) begin
      run_sample("sat_pos", 32767);
      check("sat_pos_rail", out_sat, 32767);
    end
    for (int n = 0; n < TAPS; n++) run_sample("sat_neg", -32768);
    check("sat_neg_rail", out_sat, -32768);

    // Rounding with SHIFT=4: only tap 0 contributes.
    do_reset();
    write_coef(0, 1, 1'b1);
    run_sample("rnd_p", 24);
    check("rnd_pos", out_rnd, 2);
    run_sample("rnd_n", -24);
    check("rnd_neg", out_rnd, -1);

    // Backpressure: result held, a presented sample waits until the handshake.
    for (int k = 0; k < TAPS; k++) begin
      r = 16'($urandom);
      write_coef(k, longint'(r), 1'b1);
    end
    out_ready = 1'b0;
    accept(1234);
    wait_out("bp", lat);
    held = ref_out(model_acc(), 0, 32);
    in_valid = 1'b1;
    in_data  = -16'sd777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", out_def, held);
      check("bp_vld", 64'(vld_def), 1);
      check("bp_rdy", 64'(rdy_def), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_rdy", 64'(rdy_def), 1);
    check("bp_idle_vld", 64'(vld_def), 0);
    @(posedge clk);
    for (int k = TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = -777;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("bp_pend", lat);
    check("bp_pend/lat", lat, TAPS + 1);

    // Coefficient writes during MAC and to an out-of-range address are dropped.
    accept(-4321);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'sd12345;
    @(negedge clk);
    coef_we = 1'b0;
    wait_out("guard_mac", lat);
    write_coef(13, 777, 1'b1);
    run_sample("guard_addr", 321);

    // Reset in the middle of MAC discards the sample and clears coefficients.
    accept(5000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmac_vld", 64'(vld_def), 0);
    check("rmac_busy", 64'(busy_def), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vld_def) seen++;
    end
    check("rmac_novalid", seen, 0);
    check("rmac_out", out_def, 0);
    run_sample("rmac_imp", 100);
    check("rmac_zero", out_def, 0);

    // Random coefficients and samples.
    for (int n = 0; n < 40; n++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        r = 16'($urandom);
        write_coef($urandom_range(0, 15), longint'(r), 1'b1);
      end
      r = 16'($urandom);
      run_sample($sformatf("rand%0d", n), longint'(r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Parametrised N-tap signed FIR filter with a single shared multiply-accumulate unit, iterated over the taps.
- Coefficients are run-time programmable through a write port.
- Input and output use valid/ready handshakes; output is rounded, shifted and saturated.
- Sits in the filter datapath where a fully parallel multiplier array is too costly; replaces fixed-coefficient, one-multiplier-per-tap filters.

Parameters:
- DATA_W, 16, signed input sample width
- COEF_W, 16, signed coefficient width
- TAPS, 13, number of taps (>=2)
- OUT_W, 32, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- ACC_W, DATA_W+COEF_W+clog2(TAPS), accumulator width; localparam, not overridable

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  signed input sample
- out_valid  out  1  filtered result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed filtered result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index
- coef_wdata  in  COEF_W  signed coefficient value
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - Delay line x[0..TAPS-1]=0; coefficients c[0..TAPS-1]=0; accumulator=0; tap index=0.
  - out_valid=0, out_data=0, busy=0, in_ready=1 once rst deasserts.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: x[k]<=x[k-1] for k>0, x[0]<=in_data, acc<=0, idx<=0, go to MAC.
- MAC:
  - Each cycle: acc <= acc + x[idx]*c[idx], full signed product, sign-extended to ACC_W; idx++.
  - After idx==TAPS-1 is accumulated, go to OUT.
  - Exactly TAPS MAC cycles.
- OUT entry:
  - out_data <= sat_OUT_W(round(acc >>> SHIFT)); out_valid <= 1.
  - Rounding: when SHIFT>0, add 2^(SHIFT-1) before the shift (round half up).
  - Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. No wrap, ever.
- OUT:
  - Hold out_valid and out_data stable until out_ready=1.
  - On the out_valid&&out_ready cycle: out_valid<=0, go to IDLE.
- Latency: sample accepted at cycle 0 → out_valid=1 at cycle TAPS+1.
- Throughput: one sample per TAPS+2 cycles with out_ready tied high.
- in_ready=0 in MAC and OUT; in_data is ignored there and no sample is buffered.
- Coefficient writes:
  - Taken only in IDLE: c[coef_addr]<=coef_wdata on the clock edge.
  - Ignored while busy=1, and ignored when coef_addr>=TAPS.
  - A write and a sample accept in the same IDLE cycle: the write lands, but this sample's MAC is only guaranteed to use the new value if that tap is read after the edge. Since tap 0 is read at cycle 1, the new coefficient is used for every tap.
- Reset mid-operation: any in-flight computation is discarded, no out_valid is produced, and coefficients revert to 0.
- Zero coefficients must give out_data=0 regardless of input.
- Products and accumulation are signed throughout; ACC_W guarantees no accumulator overflow.

Decomposition:
- Shared package fir_pkg:
  - clog2 function
  - state encoding constants: IDLE=2'd0, MAC=2'd1, OUT=2'd2
  - sat/round helper function, parametrised by widths
- One sub-module, fir_coef_bank: TAPS×COEF_W register file with a write port (we, addr, wdata, enable=IDLE) and an indexed combinational read port (idx).
- Delay line, MAC and FSM stay in the top module.

Test Plan:
- Impulse (defaults):
  - Load c[k]=k+1; feed 100, then 13 zeros.
  - Outputs must be 100, 200, …, 1300, then 0.
  - out_valid must rise exactly 14 cycles after each accept.
- Saturation (OUT_W=16):
  - All c=32767; feed 32767 repeatedly → outputs clamp to 32767.
  - Feed -32768 repeatedly → outputs clamp to -32768.
- Rounding (SHIFT=4):
  - c[0]=1, others 0; feed 24 → out 2 (24/16=1.5 rounds up).
  - Feed -24 → out -1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - out_data must stay stable, in_ready=0, and a sample presented meanwhile is not accepted.
  - After out_ready=1, IDLE resumes and the pending sample is accepted next cycle.
- Coefficient guard:
  - Issue coef_we during MAC → c unchanged; following output matches old coefficients.
  - Write coef_addr=13 in IDLE → no coefficient changes.
- Reset mid-MAC:
  - Assert rst at MAC cycle 5 → out_valid never asserts for that sample.
  - After release, out_data=0 and all coefficients read back 0 (impulse gives 0 output).
